// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_WIDTH : architectural register index width
//   RNONE     : register index meaning "no load destination" (x0 is never a real load target)
//   OPC_LOAD  : opcode of load instructions
//   ST_*      : FSM state encoding used by pipe_hazard_ctrl
package pipe_hazard_ctrl_pkg;

   localparam int                   REG_WIDTH = 5;
   localparam logic [REG_WIDTH-1:0] RNONE     = '0;
   localparam logic [6:0]           OPC_LOAD  = 7'b0000011;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_EX_WAIT  = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags a load in E whose destination is read by the
// instruction in D.
//   E_opcode_i : opcode in E
//   E_dstM_i   : load destination in E (RNONE = no load)
//   d_srcA_i   : rs1 of the instruction in D
//   d_srcB_i   : rs2 of the instruction in D
//   load_use_o : hazard detected
module pipe_hazard_ctrl_hazard_detect
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [6:0]           E_opcode_i,
   input  logic [REG_WIDTH-1:0] E_dstM_i,
   input  logic [REG_WIDTH-1:0] d_srcA_i,
   input  logic [REG_WIDTH-1:0] d_srcB_i,
   output logic                 load_use_o
);

   assign load_use_o = (E_opcode_i == OPC_LOAD) && (E_dstM_i != RNONE) &&
                       ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives stall/bubble controls of the F, D, E, M
// and W pipe registers, with a multi-cycle-op watchdog and perf counters.
//   clk_i, rst_ni          : clock, async active-low reset
//   E_opcode_i, E_dstM_i   : instruction in E (load detection)
//   d_srcA_i, d_srcB_i     : source registers of the instruction in D
//   e_mispredict_i         : branch in E resolved mispredicted
//   e_mc_start_i/_done_i   : multi-cycle execute op handshake
//   m_req_i, m_ack_i       : data-memory request/response
//   *_stall_o, *_bubble_o  : pipe-register controls (combinational)
//   mc_timeout_o           : one-cycle pulse when a multi-cycle op is squashed
//   stall_cnt_o            : cycles with F stalled (wrapping)
//   flush_cnt_o            : mispredict flushes taken (wrapping)
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_RUN      | normal flow; mispredict and load-use are handled here
// ST_EX_WAIT  | multi-cycle op busy in E; F/D/E held, watchdog running
// ST_MEM_WAIT | data-memory access outstanding; F..M held, W bubbled
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_WIDTH  = 32
)
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [6:0]           E_opcode_i,
   input  logic [REG_WIDTH-1:0] E_dstM_i,
   input  logic [REG_WIDTH-1:0] d_srcA_i,
   input  logic [REG_WIDTH-1:0] d_srcB_i,
   input  logic                 e_mispredict_i,
   input  logic                 e_mc_start_i,
   input  logic                 e_mc_done_i,
   input  logic                 m_req_i,
   input  logic                 m_ack_i,
   output logic                 F_stall_o,
   output logic                 D_stall_o,
   output logic                 D_bubble_o,
   output logic                 E_stall_o,
   output logic                 E_bubble_o,
   output logic                 M_stall_o,
   output logic                 M_bubble_o,
   output logic                 W_bubble_o,
   output logic                 mc_timeout_o,
   output logic [CNT_WIDTH-1:0] stall_cnt_o,
   output logic [CNT_WIDTH-1:0] flush_cnt_o
);

   localparam int              WD_W    = $clog2(MC_TIMEOUT) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

   logic [1:0]           state_q, state_d;
   logic [WD_W-1:0]      wd_q, wd_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
   logic                 load_use, flush_take, timeout;
   logic                 f_stall, d_stall, d_bubble, e_stall, e_bubble;
   logic                 m_stall, m_bubble, w_bubble;

   pipe_hazard_ctrl_hazard_detect u_hazard_detect (
      .E_opcode_i (E_opcode_i),
      .E_dstM_i   (E_dstM_i),
      .d_srcA_i   (d_srcA_i),
      .d_srcB_i   (d_srcB_i),
      .load_use_o (load_use)
   );

   // The watchdog indexes EX_WAIT cycles with the start cycle (still in RUN)
   // as cycle 0, so it is loaded with 1 on entry; cycle MC_TIMEOUT-1 squashes.
   always_comb begin
      state_d    = state_q;
      wd_d       = wd_q;
      f_stall    = 1'b0;
      d_stall    = 1'b0;
      d_bubble   = 1'b0;
      e_stall    = 1'b0;
      e_bubble   = 1'b0;
      m_stall    = 1'b0;
      m_bubble   = 1'b0;
      w_bubble   = 1'b0;
      timeout    = 1'b0;
      flush_take = 1'b0;
      case (state_q)
         ST_MEM_WAIT: begin
            if (m_ack_i) begin
               state_d = ST_RUN;
            end else begin
               {f_stall, d_stall, e_stall, m_stall, w_bubble} = '1;
            end
         end
         ST_EX_WAIT: begin
            if (e_mc_done_i) begin
               state_d = ST_RUN;
            end else if (wd_q == WD_LAST) begin
               // Squash: E takes a bubble instead of holding, and M stays
               // bubbled so the abandoned op does not advance.
               {f_stall, d_stall, e_bubble, m_bubble, timeout} = '1;
               state_d = ST_RUN;
            end else begin
               {f_stall, d_stall, e_stall, m_bubble} = '1;
               wd_d = wd_q + WD_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            if (m_req_i && !m_ack_i) begin
               {f_stall, d_stall, e_stall, m_stall, w_bubble} = '1;
               state_d = ST_MEM_WAIT;
            end else if (e_mc_start_i && !e_mc_done_i) begin
               {f_stall, d_stall, e_stall, m_bubble} = '1;
               wd_d    = WD_W'(1);
               state_d = ST_EX_WAIT;
            end else if (e_mispredict_i) begin
               {d_bubble, e_bubble} = '1;
               flush_take = 1'b1;
            end else if (load_use) begin
               {f_stall, d_stall, e_bubble} = '1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_RUN;
         wd_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         if (f_stall) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
         if (flush_take) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
   end

   // Reset forces bubbles into D..W and drops every stall without waiting for a clock.
   assign F_stall_o    = rst_ni & f_stall;
   assign D_stall_o    = rst_ni & d_stall;
   assign E_stall_o    = rst_ni & e_stall;
   assign M_stall_o    = rst_ni & m_stall;
   assign D_bubble_o   = ~rst_ni | d_bubble;
   assign E_bubble_o   = ~rst_ni | e_bubble;
   assign M_bubble_o   = ~rst_ni | m_bubble;
   assign W_bubble_o   = ~rst_ni | w_bubble;
   assign mc_timeout_o = rst_ni & timeout;
   assign stall_cnt_o  = stall_cnt_q;
   assign flush_cnt_o  = flush_cnt_q;

endmodule
